pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic.sv | 112 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer and synchronous flush that inserts a zero-control bubble.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              main_valid_n;
  logic [DATA_W-1:0] main_data_n;
  logic [CTRL_W-1:0] main_ctrl_n;
  logic              skid_valid_n;
  logic [DATA_W-1:0] skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic [1:0]        occupancy_n;

  logic accept;
  logic main_free;

  // Skid mode breaks the out_ready -> in_ready path; plain mode keeps it.
  generate
    if (HAS_SKID) begin : g_skid_ready
      assign in_ready = !skid_valid;
    end else begin : g_plain_ready
      assign in_ready = out_ready || !out_valid;
    end
  endgenerate

  assign accept    = in_valid && in_ready;
  assign main_free = !out_valid || out_ready;

  // Next-state for both slots; flush overrides every transfer.
  always_comb begin
    main_valid_n = out_valid;
    main_data_n  = out_data;
    main_ctrl_n  = out_ctrl;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_ctrl_n  = skid_ctrl;

    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_valid_n = 1'b0;
      skid_ctrl_n  = '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        main_ctrl_n  = skid_ctrl;
        skid_valid_n = HAS_SKID && accept;
        if (accept) begin
          skid_data_n = in_data;
          skid_ctrl_n = in_ctrl;
        end
      end else if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
        main_ctrl_n  = in_ctrl;
      end else begin
        main_valid_n = 1'b0;
        main_ctrl_n  = '0;
      end
    end else if (accept && HAS_SKID) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
      skid_ctrl_n  = in_ctrl;
    end

    occupancy_n = 2'(main_valid_n) + 2'(skid_valid_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      occupancy  <= '0;
    end else begin
      out_valid  <= main_valid_n;
      out_data   <= main_data_n;
      out_ctrl   <= main_ctrl_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_ctrl  <= skid_ctrl_n;
      occupancy  <= occupancy_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed checks of pipe_stage_elastic: vector table on a SKID=1 instance,
// hand-written handshake sequence on a SKID=0 instance.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic        rst1, flush1, iv1, ir1, ov1, or1;
  logic [63:0] d1, od1;
  logic [7:0]  c1, oc1;
  logic [1:0]  occ1;

  // SKID=0 instance signals
  logic        rst0, flush0, iv0, ir0, ov0, or0;
  logic [63:0] d0, od0;
  logic [7:0]  c0, oc0;
  logic [1:0]  occ0;

  pipe_stage_elastic #(.DATA_W(64), .CTRL_W(8), .SKID(1)) u_skid (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_data(d1), .in_ctrl(c1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1)
  );

  pipe_stage_elastic #(.DATA_W(64), .CTRL_W(8), .SKID(0)) u_plain (
    .clk(clk), .rst(rst0), .flush(flush0),
    .in_valid(iv0), .in_ready(ir0), .in_data(d0), .in_ctrl(c0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [63:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic [7:0]  ec;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  localparam int unsigned NV = 21;
  vec_t vt [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [63:0] d, input logic [7:0] c,
                              input logic ordy, input logic ev,
                              input logic [63:0] ed, input logic [7:0] ec,
                              input logic [1:0] eocc, input logic eir);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eocc = eocc; v.eir = eir;
    return v;
  endfunction

  initial begin
    // Expected values are the state seen after the edge that samples the inputs.
    //              rst flush iv  data     ctrl   ordy   ov  odata    octrl  occ ir
    vt[0]  = mk(1, 0, 1, 64'hDEAD, 8'h00, 1,   0, 64'h0,  8'h00, 0, 1);
    vt[1]  = mk(1, 0, 1, 64'hDEAD, 8'h00, 1,   0, 64'h0,  8'h00, 0, 1);
    for (int k = 1; k <= 8; k++)
      vt[1+k] = mk(0, 0, 1, 64'(k), 8'(8'h10 + k), 1,
                   1, 64'(k), 8'(8'h10 + k), 1, 1);
    vt[10] = mk(0, 0, 0, 64'h0,  8'h00, 1,   0, 64'h8,  8'h00, 0, 1);
    vt[11] = mk(0, 0, 1, 64'h1,  8'h21, 1,   1, 64'h1,  8'h21, 1, 1);
    vt[12] = mk(0, 0, 1, 64'h2,  8'h22, 0,   1, 64'h1,  8'h21, 2, 0);
    vt[13] = mk(0, 0, 1, 64'h3,  8'h23, 0,   1, 64'h1,  8'h21, 2, 0);
    vt[14] = mk(0, 0, 1, 64'h3,  8'h23, 1,   1, 64'h2,  8'h22, 1, 1);
    vt[15] = mk(0, 0, 1, 64'h3,  8'h23, 1,   1, 64'h3,  8'h23, 1, 1);
    vt[16] = mk(0, 0, 1, 64'h4,  8'h24, 0,   1, 64'h3,  8'h23, 2, 0);
    vt[17] = mk(0, 1, 1, 64'h99, 8'h99, 0,   0, 64'h3,  8'h00, 0, 1);
    vt[18] = mk(0, 0, 0, 64'h0,  8'h00, 1,   0, 64'h3,  8'h00, 0, 1);
    vt[19] = mk(0, 0, 1, 64'hAB, 8'hFF, 0,   1, 64'hAB, 8'hFF, 1, 1);
    vt[20] = mk(0, 0, 0, 64'h0,  8'h00, 1,   0, 64'hAB, 8'h00, 0, 1);

    rst1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; d1 = '0; c1 = '0; or1 = 1'b1;
    rst0 = 1'b1; flush0 = 1'b0; iv0 = 1'b0; d0 = '0; c0 = '0; or0 = 1'b1;

    // SKID=1: table-driven run
    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      rst1 = vt[i].rst; flush1 = vt[i].flush; iv1 = vt[i].iv;
      d1 = vt[i].d; c1 = vt[i].c; or1 = vt[i].ordy;
      @(posedge clk);
      #1;
      chk("out_valid", i, 64'(ov1),  64'(vt[i].ev));
      chk("out_data",  i, od1,       vt[i].ed);
      chk("out_ctrl",  i, 64'(oc1),  64'(vt[i].ec));
      chk("occupancy", i, 64'(occ1), 64'(vt[i].eocc));
      chk("in_ready",  i, 64'(ir1),  64'(vt[i].eir));
      if (ov1 === 1'b1 && od1 === 64'h99)
        chk("flushed_leak", i, od1, 64'h0);
    end

    // SKID=0: combinational in_ready and single-entry behaviour
    @(negedge clk);
    rst0 = 1'b0; iv0 = 1'b1; d0 = 64'h5; c0 = 8'h01; or0 = 1'b1;
    @(posedge clk); #1;
    chk("s0_load_valid", 100, 64'(ov0), 64'h1);
    chk("s0_load_data",  100, od0, 64'h5);
    @(negedge clk);
    d0 = 64'h6; c0 = 8'h02; or0 = 1'b0;
    #1;
    chk("s0_ready_low_same_cycle", 101, 64'(ir0), 64'h0);
    @(posedge clk); #1;
    chk("s0_hold_data", 102, od0, 64'h5);
    chk("s0_hold_occ",  102, 64'(occ0), 64'h1);
    @(negedge clk);
    or0 = 1'b1;
    #1;
    chk("s0_ready_high_same_cycle", 103, 64'(ir0), 64'h1);
    @(posedge clk); #1;
    chk("s0_next_data", 104, od0, 64'h6);
    chk("s0_next_ctrl", 104, 64'(oc0), 64'h02);
    chk("s0_next_occ",  104, 64'(occ0), 64'h1);
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk); #1;
    chk("s0_bubble_valid", 105, 64'(ov0), 64'h0);
    chk("s0_bubble_ctrl",  105, 64'(oc0), 64'h0);
    chk("s0_bubble_data",  105, od0, 64'h6);

    // SKID=0 flush discards a concurrent input
    @(negedge clk);
    iv0 = 1'b1; d0 = 64'h77; c0 = 8'h07;
    @(posedge clk); #1;
    @(negedge clk);
    flush0 = 1'b1; or0 = 1'b0; d0 = 64'h88;
    @(posedge clk); #1;
    chk("s0_flush_valid", 106, 64'(ov0), 64'h0);
    chk("s0_flush_ctrl",  106, 64'(oc0), 64'h0);
    chk("s0_flush_occ",   106, 64'(occ0), 64'h0);
    chk("s0_flush_data",  106, od0, 64'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
